// File: rtl/regfile_pkg.sv
// Shared constants for the 32 x 32-bit register file.
package regfile_pkg;
    localparam int REG_WIDTH = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;
    localparam int ZERO_REG  = 0;
endpackage

// File: rtl/regfile_register_32.sv
// Enabled 32-bit register with synchronous clear; one storage word of the regfile.
module register_32
    import regfile_pkg::*;
(
    input  logic                 clock,
    input  logic                 clr,
    input  logic                 in_enable,
    input  logic [REG_WIDTH-1:0] in_data,
    output logic [REG_WIDTH-1:0] out_data
);
    logic [REG_WIDTH-1:0] r_q;

    // Clear wins over enable so a write coincident with reset is dropped.
    always_ff @(posedge clock) begin
        if (clr)
            r_q <= '0;
        else if (in_enable)
            r_q <= in_data;
    end

    assign out_data = r_q;
endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file, two combinational read ports, one synchronous write port.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile
    import regfile_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ctrl_writeEnable,
    input  logic [REG_IDX_W-1:0] ctrl_writeReg,
    input  logic [REG_WIDTH-1:0] data_writeReg,
    input  logic [REG_IDX_W-1:0] ctrl_readRegA,
    input  logic [REG_IDX_W-1:0] ctrl_readRegB,
    output logic [REG_WIDTH-1:0] data_readRegA,
    output logic [REG_WIDTH-1:0] data_readRegB
);
    logic [REG_WIDTH-1:0] w_regs [REG_COUNT];
    logic [REG_COUNT-1:1] w_wr_sel;

    // r0 has no storage; it is hard-wired to zero.
    assign w_regs[ZERO_REG] = '0;

    genvar i;
    generate
        for (i = ZERO_REG + 1; i < REG_COUNT; i++) begin : g_reg
            // Gating with the enable first keeps an unknown index harmless when idle.
            assign w_wr_sel[i] = ctrl_writeEnable && (ctrl_writeReg == REG_IDX_W'(i));

            register_32 u_reg (
                .clock     (clock),
                .clr       (reset),
                .in_enable (w_wr_sel[i]),
                .in_data   (data_writeReg),
                .out_data  (w_regs[i])
            );
        end
    endgenerate

`ifdef REGFILE_WRITE_BYPASS_EN
    logic w_byp_ok;
    assign w_byp_ok = ctrl_writeEnable && !reset && (ctrl_writeReg != REG_IDX_W'(ZERO_REG));
`endif

    always_comb begin
        data_readRegA = w_regs[ctrl_readRegA];
        data_readRegB = w_regs[ctrl_readRegB];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_byp_ok && (ctrl_writeReg == ctrl_readRegA))
            data_readRegA = data_writeReg;
        if (w_byp_ok && (ctrl_writeReg == ctrl_readRegB))
            data_readRegB = data_writeReg;
`endif
    end
endmodule
